// File: rtl/max_reduce_seq_if.sv
// Operand interface between the running-maximum reducer and its producer/consumer.
// The slave modport is the reducer side; the master modport drives beats and observes the result.
interface max_reduce_seq_if #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 8
);
  logic                 start;
  logic [CNTW-1:0]      num_beats;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a_inp0;
  logic [DATAWIDTH-1:0] a_inp1;
  logic [DATAWIDTH-1:0] a_inp2;
  logic [DATAWIDTH-1:0] a_inp3;
  logic [DATAWIDTH-1:0] max_out;
  logic                 max_valid;
  logic                 busy;

  modport master (
    output start, num_beats, in_valid, a_inp0, a_inp1, a_inp2, a_inp3,
    input  in_ready, max_out, max_valid, busy
  );

  modport slave (
    input  start, num_beats, in_valid, a_inp0, a_inp1, a_inp2, a_inp3,
    output in_ready, max_out, max_valid, busy
  );
endinterface

// File: rtl/max_reduce_seq.sv
// Sequential FP16 running-maximum reducer: four lanes per beat, a registered lane-max
// stage feeding a running-max register that drives the softmax x-minus-max operand.
module max_reduce_seq #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 8
) (
  input logic              clk,
  input logic              resetn,
  max_reduce_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Sign-magnitude mapped to an unsigned key so one integer compare gives the total order;
  // both zeros share one key so they compare equal.
  function automatic logic [DATAWIDTH-1:0] orderKey(input logic [DATAWIDTH-1:0] v);
    logic [DATAWIDTH-2:0] mag;
    mag = v[DATAWIDTH-2:0];
    if (mag == '0) begin
      orderKey = {1'b1, {(DATAWIDTH-1){1'b0}}};
    end else if (v[DATAWIDTH-1]) begin
      orderKey = {1'b0, ~mag};
    end else begin
      orderKey = {1'b1, mag};
    end
  endfunction

  function automatic logic isGreater(input logic [DATAWIDTH-1:0] a,
                                     input logic [DATAWIDTH-1:0] b);
    isGreater = orderKey(a) > orderKey(b);
  endfunction

  state_t               r_state;
  logic [CNTW-1:0]      r_count;
  logic                 r_inReady;
  logic                 r_busy;
  logic                 r_maxValid;
  logic                 r_s1Valid;
  logic                 r_first;
  logic [DATAWIDTH-1:0] r_laneMax;
  logic [DATAWIDTH-1:0] r_running;

  logic                 w_accept;
  logic                 w_startAccept;
  logic [DATAWIDTH-1:0] w_max01;
  logic [DATAWIDTH-1:0] w_max23;
  logic [DATAWIDTH-1:0] w_laneMax;

  assign w_accept      = r_inReady & bus.in_valid;
  assign w_startAccept = (r_state == S_IDLE) && bus.start && (bus.num_beats != '0);

  // Lower lane index is kept on ties at every level of the tree.
  assign w_max01   = isGreater(bus.a_inp1, bus.a_inp0) ? bus.a_inp1 : bus.a_inp0;
  assign w_max23   = isGreater(bus.a_inp3, bus.a_inp2) ? bus.a_inp3 : bus.a_inp2;
  assign w_laneMax = isGreater(w_max23, w_max01) ? w_max23 : w_max01;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_inReady  <= 1'b0;
      r_busy     <= 1'b0;
      r_maxValid <= 1'b0;
    end else begin
      r_maxValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_startAccept) begin
            r_state   <= S_ACCUM;
            r_count   <= bus.num_beats;
            r_busy    <= 1'b1;
            r_inReady <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_count <= r_count - 1'b1;
            if (r_count == CNTW'(1)) begin
              r_state   <= S_DRAIN;
              r_inReady <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_maxValid <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The first beat after a start overwrites the running max, so nothing survives from an older vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1Valid <= 1'b0;
      r_first   <= 1'b0;
      r_laneMax <= '0;
      r_running <= '0;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_laneMax <= w_laneMax;
      end
      if (w_startAccept) begin
        r_first <= 1'b1;
      end
      if (r_s1Valid) begin
        if (r_first || isGreater(r_laneMax, r_running)) begin
          r_running <= r_laneMax;
        end
        r_first <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.busy      = r_busy;
  assign bus.max_valid = r_maxValid;
  assign bus.max_out   = r_running;

endmodule

// File: doc/max_reduce_seq.md
Name: max_reduce_seq

Overview:
- Sequential running-maximum reducer for the softmax datapath.
- Consumes a vector of FP16 values, four lanes per beat, over a programmed number of beats, and returns the single maximum.
- Its max_out drives the shared b_inp operand of the four-lane x-minus-max subtraction stage; it is the producer end of that operand interface.

Parameters:
- DATAWIDTH, 16, element width (IEEE half: 1 sign, 5 exponent, 10 mantissa).
- CNTW, 8, width of the beat-count input; maximum vector length is 4*(2^CNTW-1) elements.

Ports:
- clk  input  1  clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a reduction when idle.
- num_beats  input  CNTW  beats in the vector; sampled on start.
- in_valid  input  1  a_inp0..a_inp3 carry a valid beat.
- in_ready  output  1  block accepts a beat this cycle.
- a_inp0  input  DATAWIDTH  lane 0 element.
- a_inp1  input  DATAWIDTH  lane 1 element.
- a_inp2  input  DATAWIDTH  lane 2 element.
- a_inp3  input  DATAWIDTH  lane 3 element.
- max_out  output  DATAWIDTH  reduced maximum; held stable until the next start.
- max_valid  output  1  one-cycle pulse when max_out is final.
- busy  output  1  high from an accepted start until max_valid is asserted.

Behaviour:
- Reset (async, resetn=0) clears state to IDLE and sets in_ready=0, max_out=16'h0000, max_valid=0, busy=0, beat counter=0, and the stage-1 valid flag to 0. Reset mid-reduction abandons the reduction without producing a max_valid.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE to ACCUM: start=1 and num_beats!=0. The counter loads num_beats and busy goes high the next cycle. A start with num_beats==0 is ignored: the block stays in IDLE with no pulse.
- ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready, and each accepted beat decrements the counter. Accepting the beat that takes the counter to 0 moves the FSM to DRAIN. in_valid=0 stalls the FSM with no state change.
- DRAIN: in_ready=0. Waits one cycle for the final stage-2 update, then moves to DONE.
- DONE: max_valid=1 for exactly one cycle, then IDLE, and busy drops in the same cycle. max_out keeps its value.
- start while busy is ignored.
- Stage 1 (registered): the 4-lane compare tree selects the lane maximum on the accept edge and sets stage-1 valid.
- Stage 2: when stage-1 valid is set, the running max updates on the next edge. The first beat of a reduction loads the running max directly; later beats replace it only if lane_max > running.
- Latency: if the last beat is accepted on edge T, the running max is final at edge T+1 and max_valid is high in the cycle after edge T+2.
- Compare rule is an FP16 total order on sign-magnitude:
  - Positive values are larger than negative values.
  - Among positives, larger magnitude bits win; among negatives, smaller magnitude bits win.
  - +0 and -0 compare equal.
  - Ties keep the incumbent. In the tree, the lower lane index wins ties.
  - Infinities order naturally.
  - NaN inputs are outside the contract, and the result is then undefined.
- No arithmetic is performed; outputs are bit-exact copies of an input element.

Test Plan:
- Single beat, num_beats=1, lanes {3C00,4000,BC00,3800} -> max_out=4000, max_valid high exactly at accept+3 edges, busy high throughout.
- Three beats with in_valid gaps, all-negative inputs {BC00,C000,C200,C400},{C400,C000,BC01,C200},{C000,C000,C000,BE00} -> max_out=BC00. in_ready stays 1 during the gaps, and the counter does not decrement on gaps.
- Zero tie, lanes {8000,0000,8000,8000}, one beat -> max_out=8000 (lane 0 wins the tie). A second vector with 0000 in lane 0 -> max_out=0000.
- Infinity, beat 2 contains 7C00 among finite values -> max_out=7C00. Also start with num_beats=0 -> no busy and no max_valid for 10 cycles.
- Robustness: start pulsed during ACCUM -> ignored and the result is unchanged. resetn asserted mid-ACCUM -> all outputs reach reset values immediately. A fresh start after reset yields the correct max with no carry-over from the old running value.
